// File: rtl/dw2_11_calc_pkg.sv
// Shared constants, saturation limits and FSM encoding for the dw2_11
// delta-weight calculator.
package dw2_11_calc_pkg;

    localparam int          DEF_WIDTH     = 32;
    localparam int          DEF_FRAC_BITS = 24;
    localparam logic [31:0] ETA_DEFAULT   = 32'h0019_9999;  // 0.1 in Q8.24

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_DA  = 2'd1,
        MUL_ETA = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/dw2_11_calc_mul.sv
// Serial sign-magnitude fixed-point multiplier: one partial product per cycle,
// result shifted right by FRAC_BITS (toward zero) and saturated.
module fx_mul_serial
    import dw2_11_calc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CW         = $clog2(WIDTH);
    localparam int               LW         = WIDTH - FRAC_BITS;
    localparam logic [CW-1:0]    LAST       = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    FRAC_START = CW'(FRAC_BITS);
    localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    acc_hi;
    logic [LW-1:0]       acc_lo;
    logic                neg;
    logic                running;
    logic [CW-1:0]       cnt;
    logic [WIDTH:0]      sum;
    logic [WIDTH+LW-1:0] quot;
    logic                big;

    // Magnitude of the most negative value is 2^(WIDTH-1), which fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign done = running && (cnt == LAST);

    always_comb begin
        sum = {1'b0, acc_hi};
        if (mplier[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
    end

    // Right-shifting accumulator: bits below FRAC_BITS are shifted out and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier  <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            mplier  <= mag(op_a);
            mcand   <= mag(op_b);
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            acc_hi <= sum[WIDTH:1];
            if (cnt >= FRAC_START) acc_lo <= {sum[0], acc_lo[LW-1:1]};
            cnt <= cnt + 1'b1;
            if (done) running <= 1'b0;
        end
    end

    always_comb begin
        quot = {acc_hi, acc_lo};
        big  = |quot[WIDTH+LW-1:WIDTH-1];
        if (neg) result = big ? MIN_NEG : (~quot[WIDTH-1:0] + 1'b1);
        else     result = big ? MAX_POS : quot[WIDTH-1:0];
    end

endmodule

// File: rtl/dw2_11_calc.sv
// Output-layer weight delta dw2_11 = ETA * (delta2_1 * a1_1), computed with one
// shared serial multiplier; pulses select_update when the new delta is loaded.
module dw2_11_calc
    import dw2_11_calc_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               FRAC_BITS = DEF_FRAC_BITS,
    parameter logic [WIDTH-1:0] ETA       = ETA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] delta2_1,
    input  logic [WIDTH-1:0] a1_1,
    output logic             busy,
    output logic [WIDTH-1:0] dw2_11,
    output logic             select_update,
    output logic [1:0]       fsm_state
);

    state_t           state;
    logic             eta_first;
    logic             mul_load;
    logic             mul_done;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_result;

    assign fsm_state = state;

    // First multiply loads straight from the inputs on the accepting edge; the
    // ETA multiply loads from the saturated intermediate one cycle into MUL_ETA.
    assign mul_load = ((state == IDLE) && start) || ((state == MUL_ETA) && eta_first);
    assign mul_a    = (state == IDLE) ? delta2_1 : ETA;
    assign mul_b    = (state == IDLE) ? a1_1 : mul_result;

    fx_mul_serial #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .clk    (clk),
        .rst_n  (reset),
        .load   (mul_load),
        .op_a   (mul_a),
        .op_b   (mul_b),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            select_update <= 1'b0;
            dw2_11        <= '0;
            eta_first     <= 1'b0;
        end else begin
            select_update <= 1'b0;
            eta_first     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= MUL_DA;
                    end
                end
                MUL_DA: begin
                    if (mul_done) begin
                        eta_first <= 1'b1;
                        state     <= MUL_ETA;
                    end
                end
                MUL_ETA: begin
                    if (mul_done && !eta_first) state <= DONE;
                end
                DONE: begin
                    dw2_11        <= mul_result;
                    select_update <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dw2_11_calc.sv
// Directed bench for dw2_11_calc: latency, fixed-point results, saturation,
// start filtering and reset abort.
module tb_dw2_11_calc;
    import dw2_11_calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] delta2_1;
    logic [31:0] a1_1;
    logic        busy;
    logic [31:0] dw2_11;
    logic        select_update;
    logic [1:0]  fsm_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;
    int n;
    int pulses;

    dw2_11_calc dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .delta2_1      (delta2_1),
        .a1_1          (a1_1),
        .busy          (busy),
        .dw2_11        (dw2_11),
        .select_update (select_update),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until select_update is seen, capped at 200.
    task automatic wait_pulse(output int edges);
        edges = 0;
        while (edges < 200) begin
            tick();
            edges++;
            if (select_update) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [31:0] a,
                          input logic [31:0] exp);
        int e;
        delta2_1 = d;
        a1_1     = a;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_pulse(e);
        check({tag, "_edge"}, e, 32'd66);
        check({tag, "_dw"}, dw2_11, exp);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_one_pulse"}, {31'd0, select_update}, 32'd0);
        check({tag, "_hold"}, dw2_11, exp);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        delta2_1 = '0;
        a1_1     = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {31'd0, select_update}, 32'd0);
        check("rst_dw", dw2_11, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_state", {30'd0, fsm_state}, 32'(IDLE));

        run_op("one_x_one", 32'h0100_0000, 32'h0100_0000, 32'h0019_9999);
        run_op("neg_half_x_two", 32'hFF80_0000, 32'h0200_0000, 32'hFFE6_6667);
        run_op("sat_intermediate", 32'h7F00_0000, 32'h7F00_0000, 32'h0CCC_CC7F);
        run_op("zero_operand", 32'h0000_0000, 32'h0100_0000, 32'h0000_0000);
        run_op("min_neg_x_one", SAT_NEG, 32'h0100_0000, 32'hF333_3380);
        run_op("min_neg_sq", SAT_NEG, SAT_NEG, 32'h0CCC_CC7F);

        // Second start at edge 10 is ignored; a start right after the pulse is taken.
        delta2_1 = 32'h0100_0000;
        a1_1     = 32'h0100_0000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        delta2_1 = 32'h0200_0000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_state", {30'd0, fsm_state}, 32'(MUL_DA));
        wait_pulse(n);
        check("ignore_edge", n + 10, 32'd66);
        check("ignore_dw", dw2_11, 32'h0019_9999);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_pulse(n);
        check("restart_edge", n + 67, 32'd133);
        check("restart_dw", dw2_11, 32'h0033_3332);
        tick();

        // Start held high relaunches on the first IDLE edge after DONE.
        delta2_1 = 32'hFF00_0000;
        a1_1     = 32'h0100_0000;
        start    = 1'b1;
        tick();
        wait_pulse(n);
        check("held_edge", n, 32'd66);
        check("held_dw", dw2_11, 32'hFFE6_6667);
        tick();
        start = 1'b0;
        check("held_relaunch", {30'd0, fsm_state}, 32'(MUL_DA));
        wait_pulse(n);
        check("held_edge2", n, 32'd66);
        tick();

        // Reset in the middle of MUL_DA aborts with no pulse.
        delta2_1 = 32'h0100_0000;
        a1_1     = 32'h0100_0000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dw", dw2_11, 32'd0);
        check("abort_state", {30'd0, fsm_state}, 32'(IDLE));
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (select_update) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        check("abort_dw_kept", dw2_11, 32'd0);
        run_op("after_reset", 32'h0100_0000, 32'h0100_0000, 32'h0019_9999);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
